// File: rtl/fp_mul_result_stage.sv
// ============================================================================
// Module   : fp_mul_result_stage
// Function : Registered result stage after the FP32 multiplier: special-class
//            substitution, valid/ready FIFO, sticky flags, saturating counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_mul_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_sign,
    input  logic [2:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_class,
    input  logic             flag_clr,
    output logic             flag_nv,
    output logic             flag_of,
    output logic             flag_uf,
    output logic [CNT_W-1:0] cnt_ops,
    output logic [CNT_W-1:0] cnt_exc
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = PTR_W + 1;

    localparam logic [FILL_W-1:0] c_depth = FILL_W'(DEPTH);
    localparam logic [PTR_W-1:0]  c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};

    localparam logic [2:0] c_cls_ovf  = 3'd0;
    localparam logic [2:0] c_cls_unf  = 3'd1;
    localparam logic [2:0] c_cls_nan  = 3'd2;
    localparam logic [2:0] c_cls_pinf = 3'd3;
    localparam logic [2:0] c_cls_ninf = 3'd4;
    localparam logic [2:0] c_cls_zero = 3'd5;
    localparam logic [2:0] c_cls_norm = 3'd6;
    localparam logic [2:0] c_cls_ill  = 3'd7;

    localparam logic [31:0] c_qnan = 32'h7FC0_0000;
    localparam logic [31:0] c_pinf = 32'h7F80_0000;
    localparam logic [31:0] c_ninf = 32'hFF80_0000;

    logic [31:0]       r_mem_result [DEPTH];
    logic [2:0]        r_mem_class  [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FILL_W-1:0] r_count;

    logic              r_flag_nv;
    logic              r_flag_of;
    logic              r_flag_uf;
    logic [CNT_W-1:0]  r_cnt_ops;
    logic [CNT_W-1:0]  r_cnt_exc;

    logic              w_accept;
    logic              w_release;
    logic              w_not_empty;
    logic [31:0]       w_store_word;

    logic              w_nv_next;
    logic              w_of_next;
    logic              w_uf_next;
    logic [CNT_W-1:0]  w_ops_base;
    logic [CNT_W-1:0]  w_exc_base;
    logic [CNT_W-1:0]  w_ops_next;
    logic [CNT_W-1:0]  w_exc_next;
    logic              w_is_exc;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign w_not_empty = (r_count != '0);
    assign in_ready    = (r_count != c_depth);
    assign out_valid   = w_not_empty;
    assign w_accept    = in_valid & in_ready;
    assign w_release   = w_not_empty & out_ready;

    // in_result is only meaningful for normalized results; every other class
    // is rebuilt from the sign so an undefined mantissa never gets stored.
    always_comb begin
        w_store_word = c_qnan;
        case (in_class)
            c_cls_norm: w_store_word = in_result;
            c_cls_zero: w_store_word = {in_sign, 31'h0};
            c_cls_unf:  w_store_word = {in_sign, 31'h0};
            c_cls_ovf:  w_store_word = {in_sign, 8'hFF, 23'h0};
            c_cls_pinf: w_store_word = c_pinf;
            c_cls_ninf: w_store_word = c_ninf;
            c_cls_nan:  w_store_word = c_qnan;
            default:    w_store_word = c_qnan;
        endcase
    end

    // ------------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_result[i] <= '0;
                r_mem_class[i]  <= '0;
            end
        end else if (w_accept) begin
            r_mem_result[r_wr_ptr] <= w_store_word;
            r_mem_class[r_wr_ptr]  <= in_class;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_release) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_accept, w_release})
                2'b10:   r_count <= r_count + FILL_W'(1);
                2'b01:   r_count <= r_count - FILL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is forced to zero while empty so stale entries are never visible.
    assign out_result = w_not_empty ? r_mem_result[r_rd_ptr] : '0;
    assign out_class  = w_not_empty ? r_mem_class[r_rd_ptr]  : '0;

    // ------------------------------------------------------------------------
    // Sticky flags and saturating counters: clear first, then this cycle's event
    // ------------------------------------------------------------------------
    assign w_is_exc   = (in_class == c_cls_ovf) || (in_class == c_cls_unf) ||
                        (in_class == c_cls_nan);

    assign w_nv_next  = (r_flag_nv & ~flag_clr) |
                        (w_accept & ((in_class == c_cls_nan) || (in_class == c_cls_ill)));
    assign w_of_next  = (r_flag_of & ~flag_clr) | (w_accept & (in_class == c_cls_ovf));
    assign w_uf_next  = (r_flag_uf & ~flag_clr) | (w_accept & (in_class == c_cls_unf));

    assign w_ops_base = flag_clr ? '0 : r_cnt_ops;
    assign w_exc_base = flag_clr ? '0 : r_cnt_exc;

    assign w_ops_next = (w_accept && (w_ops_base != c_cnt_max))
                        ? w_ops_base + CNT_W'(1) : w_ops_base;
    assign w_exc_next = (w_accept && w_is_exc && (w_exc_base != c_cnt_max))
                        ? w_exc_base + CNT_W'(1) : w_exc_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_nv <= 1'b0;
            r_flag_of <= 1'b0;
            r_flag_uf <= 1'b0;
            r_cnt_ops <= '0;
            r_cnt_exc <= '0;
        end else begin
            r_flag_nv <= w_nv_next;
            r_flag_of <= w_of_next;
            r_flag_uf <= w_uf_next;
            r_cnt_ops <= w_ops_next;
            r_cnt_exc <= w_exc_next;
        end
    end

    assign flag_nv = r_flag_nv;
    assign flag_of = r_flag_of;
    assign flag_uf = r_flag_uf;
    assign cnt_ops = r_cnt_ops;
    assign cnt_exc = r_cnt_exc;

    // ------------------------------------------------------------------------
    // Simulation-only protocol checks
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_in_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> in_valid)
        else $error("in_valid dropped before being accepted");

    a_in_class_known: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> !$isunknown(in_class))
        else $error("in_class unknown while in_valid");

    a_in_class_legal: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> (in_class != c_cls_ill))
        else $error("illegal in_class 7 presented");

    a_out_result_known: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> !$isunknown(out_result))
        else $error("out_result unknown while out_valid");
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_result_stage.sv
// ============================================================================
// Module   : tb_fp_mul_result_stage
// Function : Self-checking bench; queue-based reference model, two counter widths.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_result_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_result;
    logic        in_sign;
    logic [2:0]  in_class;
    logic        out_ready;
    logic        flag_clr;

    logic        in_ready,  s_in_ready;
    logic        out_valid, s_out_valid;
    logic [31:0] out_result, s_out_result;
    logic [2:0]  out_class, s_out_class;
    logic        flag_nv, flag_of, flag_uf;
    logic        s_flag_nv, s_flag_of, s_flag_uf;
    logic [15:0] cnt_ops, cnt_exc;
    logic [3:0]  s_cnt_ops, s_cnt_exc;

    always #5 clk = ~clk;

    fp_mul_result_stage #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_sign(in_sign), .in_class(in_class),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_class(out_class),
        .flag_clr(flag_clr), .flag_nv(flag_nv), .flag_of(flag_of), .flag_uf(flag_uf),
        .cnt_ops(cnt_ops), .cnt_exc(cnt_exc)
    );

    fp_mul_result_stage #(.DEPTH(DEPTH), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_result(in_result),
        .in_sign(in_sign), .in_class(in_class),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_result(s_out_result), .out_class(s_out_class),
        .flag_clr(flag_clr), .flag_nv(s_flag_nv), .flag_of(s_flag_of), .flag_uf(s_flag_uf),
        .cnt_ops(s_cnt_ops), .cnt_exc(s_cnt_exc)
    );

    // Reference model state: queue of {class, word}, plain integer counters
    logic [34:0] mq [$];
    int  m_ops, m_exc;
    bit  m_nv, m_of, m_uf;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [2:0] cls, input logic s,
                                             input logic [31:0] r);
        case (cls)
            3'd6:       return r;
            3'd5, 3'd1: return s ? 32'h8000_0000 : 32'h0000_0000;
            3'd0:       return s ? 32'hFF80_0000 : 32'h7F80_0000;
            3'd3:       return 32'h7F80_0000;
            3'd4:       return 32'hFF80_0000;
            default:    return 32'h7FC0_0000;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ops = 0; m_exc = 0;
        m_nv = 0; m_of = 0; m_uf = 0;
    endtask

    task automatic check_all();
        check("in_ready",    32'(in_ready),    32'(mq.size() < DEPTH));
        check("s_in_ready",  32'(s_in_ready),  32'(mq.size() < DEPTH));
        check("out_valid",   32'(out_valid),   32'(mq.size() != 0));
        check("s_out_valid", 32'(s_out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_result",   out_result,        mq[0][31:0]);
            check("out_class",    32'(out_class),    32'(mq[0][34:32]));
            check("s_out_result", s_out_result,      mq[0][31:0]);
        end
        check("flag_nv",   32'(flag_nv),   32'(m_nv));
        check("flag_of",   32'(flag_of),   32'(m_of));
        check("flag_uf",   32'(flag_uf),   32'(m_uf));
        check("cnt_ops",   32'(cnt_ops),   32'(sat(m_ops, 16)));
        check("cnt_exc",   32'(cnt_exc),   32'(sat(m_exc, 16)));
        check("s_cnt_ops", 32'(s_cnt_ops), 32'(sat(m_ops, 4)));
        check("s_cnt_exc", 32'(s_cnt_exc), 32'(sat(m_exc, 4)));
    endtask

    // Applies the current inputs for one clock and advances the model
    task automatic step(output bit acc);
        bit          rel;
        logic [34:0] dropped;
        acc = in_valid && (mq.size() < DEPTH);
        rel = out_ready && (mq.size() > 0);
        if (rel) dropped = mq.pop_front();
        if (flag_clr) begin
            m_ops = 0; m_exc = 0; m_nv = 0; m_of = 0; m_uf = 0;
        end
        if (acc) begin
            mq.push_back({in_class, ref_word(in_class, in_sign, in_result)});
            m_ops++;
            if (in_class <= 3'd2) m_exc++;
            if (in_class == 3'd2) m_nv = 1;
            if (in_class == 3'd0) m_of = 1;
            if (in_class == 3'd1) m_uf = 1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push(input logic [2:0] cls, input logic s, input logic [31:0] r);
        bit acc;
        int guard;
        in_valid = 1'b1; in_class = cls; in_sign = s; in_result = r;
        acc = 0;
        guard = 0;
        while (!acc && guard < 50) begin
            step(acc);
            guard++;
        end
        if (!acc) check("push_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(acc);
    endtask

    logic [31:0] spec_exp [6] = '{32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000,
                                  32'h7F80_0000, 32'hFF80_0000, 32'h8000_0000};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          acc;
        bit          pending;
        logic [31:0] head;

        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_sign = 1'b0;
        in_class = 3'd6; out_ready = 1'b0; flag_clr = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid",  32'(out_valid), 32'd0);
        check("rst_in_ready",   32'(in_ready),  32'd1);
        check("rst_out_result", out_result,     32'd0);
        check("rst_out_class",  32'(out_class), 32'd0);
        check("rst_cnt_ops",    32'(cnt_ops),   32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Pass-through
        out_ready = 1'b1;
        push(3'd6, 1'b0, 32'h4049_0FDB);
        check("pass_result",  out_result,   32'h4049_0FDB);
        check("pass_cnt_ops", 32'(cnt_ops), 32'd1);
        idle(1);

        // Special classes with negative sign
        for (int c = 0; c < 6; c++) begin
            push(3'(c), 1'b1, $urandom);
            check($sformatf("special_c%0d", c), out_result, spec_exp[c]);
        end
        idle(2);
        check("special_of",  32'(flag_of), 32'd1);
        check("special_uf",  32'(flag_uf), 32'd1);
        check("special_nv",  32'(flag_nv), 32'd1);
        check("special_exc", 32'(cnt_exc), 32'd3);

        // Backpressure: third push stalls while full, head stable
        out_ready = 1'b0;
        push(3'd6, 1'b0, 32'h1111_1111);
        push(3'd6, 1'b0, 32'h2222_2222);
        check("bp_full", 32'(in_ready), 32'd0);
        head = out_result;
        in_valid = 1'b1; in_class = 3'd6; in_sign = 1'b0; in_result = 32'h3333_3333;
        step(acc);
        check("bp_no_accept", 32'(acc), 32'd0);
        step(acc);
        check("bp_head_stable", out_result, head);
        check("bp_head_value",  out_result, 32'h1111_1111);
        out_ready = 1'b1;
        step(acc);
        check("bp_head_next", out_result, 32'h2222_2222);
        step(acc);
        check("bp_simul_acc", 32'(acc), 32'd1);
        in_valid = 1'b0;
        check("bp_order", out_result, 32'h3333_3333);
        idle(2);

        // Clear coincident with an overflow accept
        flag_clr = 1'b1;
        push(3'd0, 1'b0, $urandom);
        flag_clr = 1'b0;
        check("clr_flag_of", 32'(flag_of), 32'd1);
        check("clr_flag_nv", 32'(flag_nv), 32'd0);
        check("clr_cnt_ops", 32'(cnt_ops), 32'd1);
        check("clr_cnt_exc", 32'(cnt_exc), 32'd1);

        // Saturation of the narrow counter, pointers wrapping many times
        for (int k = 0; k < 20; k++) push(3'd6, 1'b0, $urandom);
        idle(2);
        check("sat_s_cnt_ops", 32'(s_cnt_ops), 32'd15);
        check("sat_cnt_ops",   32'(cnt_ops),   32'd21);

        // Randomized traffic; in_valid held until accepted
        pending = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pending) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_class  = 3'($urandom_range(0, 6));
                in_sign   = 1'($urandom);
                in_result = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flag_clr  = ($urandom_range(0, 15) == 0);
            step(acc);
            pending = in_valid && !acc;
        end
        while (pending) begin
            step(acc);
            pending = !acc;
        end
        in_valid = 1'b0; flag_clr = 1'b0;

        // Asynchronous reset mid-stream with two entries queued
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        push(3'd2, 1'b0, $urandom);
        push(3'd6, 1'b1, 32'hC000_0000);
        check("mid_two_queued", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_flag_nv",   32'(flag_nv),   32'd0);
        check("mid_rst_cnt_ops",   32'(cnt_ops),   32'd0);
        check("mid_rst_cnt_exc",   32'(cnt_exc),   32'd0);
        check("mid_rst_result",    out_result,     32'd0);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(2);
        push(3'd6, 1'b0, 32'h3F80_0000);
        check("post_rst_result", out_result, 32'h3F80_0000);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
